// File: rtl/mac_tx_arb_pkg.sv
// Shared types and helpers for the MAC transmit stream arbiter and its
// receive-side counterpart: FSM encoding, default packet limit, rotate pick.
package mac_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2
    } arb_state_e;

    // 1536 bytes at a 32-bit beat.
    localparam int MAX_BEATS_DEF = 384;

    typedef struct packed {
        logic [1:0] idx;
        logic       found;
    } rr_pick_t;

    // First set bit of req searching ptr, ptr+1, ... modulo n (n <= 4, ptr < n).
    function automatic rr_pick_t rr_pick(input logic [3:0] req, input logic [1:0] ptr,
                                         input int unsigned n);
        rr_pick_t    r;
        int unsigned cand;
        r.idx   = 2'd0;
        r.found = 1'b0;
        for (int unsigned k = 0; k < 4; k++) begin
            cand = {30'd0, ptr} + k;
            if (cand >= n) cand = cand - n;
            if (k < n && !r.found && req[cand[1:0]]) begin
                r.idx   = cand[1:0];
                r.found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mac_tx_stream_arb_if.sv
// AXI-Stream bundle between NUM_SRC user-side requesters and the MAC transmit input.
interface mac_tx_stream_arb_if #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 32
);
    localparam int STRB_W = DATA_W / 8;

    // valid/ready: a beat moves on a rising Clk where tvalid and tready are both
    // high; tvalid never waits on tready, and payload is held stable while stalled.
    logic [NUM_SRC-1:0]        S_tvalid;
    logic [NUM_SRC-1:0]        S_tready;
    logic [NUM_SRC*DATA_W-1:0] S_tdata;
    logic [NUM_SRC*STRB_W-1:0] S_tstrb;
    logic [NUM_SRC-1:0]        S_tlast;

    logic                      M_tvalid;
    logic                      M_tready;
    logic [DATA_W-1:0]         M_tdata;
    logic [STRB_W-1:0]         M_tstrb;
    logic                      M_tlast;

    modport master (
        input  S_tvalid, S_tdata, S_tstrb, S_tlast, M_tready,
        output S_tready, M_tvalid, M_tdata, M_tstrb, M_tlast
    );

    modport slave (
        output S_tvalid, S_tdata, S_tstrb, S_tlast, M_tready,
        input  S_tready, M_tvalid, M_tdata, M_tstrb, M_tlast
    );

endinterface

// File: rtl/mac_tx_rr_pick.sv
// Combinational rotate-priority encoder: first requester at or after ptr wins.
module mac_tx_rr_pick
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [1:0]         ptr,
    output logic [1:0]         idx,
    output logic               found
);

    logic [3:0] req_w;
    rr_pick_t   res;

    always_comb begin
        req_w              = 4'd0;
        req_w[NUM_SRC-1:0] = req;
        res                = rr_pick(req_w, ptr, NUM_SRC);
        idx                = res.idx;
        found              = res.found;
    end

endmodule

// File: rtl/mac_tx_stream_arb.sv
// Packet-atomic round-robin arbiter feeding the MAC transmit stream, with a
// per-packet beat watchdog that truncates runaway packets and drains the rest.
module mac_tx_stream_arb
    import mac_tx_arb_pkg::*;
#(
    parameter int NUM_SRC   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BEATS = MAX_BEATS_DEF
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [NUM_SRC-1:0] Src_en,
    mac_tx_stream_arb_if.master axis,
    output logic [1:0]         Grant_id,
    output logic               Busy,
    output logic               Trunc_err,
    output logic [1:0]         dbg_state
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(MAX_BEATS + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_XFER  = XFER;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]       state;
    logic [1:0]       rr_ptr;
    logic [CNT_W-1:0] beat_cnt;

    logic [1:0]       pick_idx;
    logic             pick_found;
    logic [1:0]       next_ptr;

    logic             src_valid;
    logic             src_last;
    logic             at_limit;
    logic             beat_acc;

    mac_tx_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req   (axis.S_tvalid & Src_en),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign next_ptr  = (pick_idx == 2'(NUM_SRC - 1)) ? 2'd0 : pick_idx + 2'd1;
    assign src_valid = axis.S_tvalid[Grant_id];
    assign src_last  = axis.S_tlast[Grant_id];
    assign at_limit  = (beat_cnt == CNT_W'(MAX_BEATS - 1));
    assign beat_acc  = (state == ST_XFER) && src_valid && axis.M_tready;
    assign Busy      = (state != ST_IDLE);
    assign dbg_state = state;

    // The output is a pure mux of the granted source; nothing passes outside XFER.
    always_comb begin
        axis.M_tvalid = 1'b0;
        axis.M_tdata  = '0;
        axis.M_tstrb  = '0;
        axis.M_tlast  = 1'b0;
        axis.S_tready = '0;
        case (state)
            ST_XFER: begin
                axis.M_tvalid           = src_valid;
                axis.M_tdata            = axis.S_tdata[Grant_id*DATA_W +: DATA_W];
                axis.M_tstrb            = axis.S_tstrb[Grant_id*STRB_W +: STRB_W];
                axis.M_tlast            = src_last | at_limit;
                axis.S_tready[Grant_id] = axis.M_tready;
            end
            ST_DRAIN: begin
                axis.S_tready[Grant_id] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            Grant_id  <= 2'd0;
            rr_ptr    <= 2'd0;
            beat_cnt  <= '0;
            Trunc_err <= 1'b0;
        end else begin
            Trunc_err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        Grant_id <= pick_idx;
                        rr_ptr   <= next_ptr;
                        beat_cnt <= '0;
                        state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat_acc) begin
                        if (beat_cnt != CNT_W'(MAX_BEATS)) beat_cnt <= beat_cnt + CNT_W'(1);
                        if (src_last) begin
                            state <= ST_IDLE;
                        end else if (at_limit) begin
                            Trunc_err <= 1'b1;
                            state     <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    // Discard the tail of a truncated packet up to its own tlast.
                    if (src_valid && src_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_stream_arb.sv
// Directed bench for mac_tx_stream_arb: per-source drivers, expected-beat queue
// checked by a negedge monitor, plus directed timing and status checks.
module tb_mac_tx_stream_arb;

    localparam int NS   = 4;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int MAXB = 8;
    localparam int EW   = 2 + 1 + SW + DW;
    localparam int TMO  = 200;

    logic          Clk;
    logic          Reset;
    logic [NS-1:0] Src_en;
    logic [1:0]    Grant_id;
    logic          Busy;
    logic          Trunc_err;
    logic [1:0]    dbg_state;

    mac_tx_stream_arb_if #(.NUM_SRC(NS), .DATA_W(DW)) axis_if ();

    mac_tx_stream_arb #(.NUM_SRC(NS), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Src_en    (Src_en),
        .axis      (axis_if),
        .Grant_id  (Grant_id),
        .Busy      (Busy),
        .Trunc_err (Trunc_err),
        .dbg_state (dbg_state)
    );

    logic [EW-1:0] exp_q[$];
    int            beat_cyc[$];
    int            n_cmp = 0;
    int            n_err = 0;
    int            n_beats = 0;
    int            n_trunc = 0;
    int            cyc = 0;
    bit            chk_ready = 0;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    function automatic logic [DW-1:0] mk_data(input int src, input int pkt, input int b);
        return {8'hA0 + 8'(src), 8'(pkt), 16'(b)};
    endfunction

    function automatic logic [SW-1:0] mk_strb(input int b, input int n);
        return (b == n - 1) ? 4'h3 : 4'hF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected output beats: grant, last (source tlast or watchdog), strb, data.
    task automatic push_exp(input int src, input int n_out, input int n_total, input int pkt);
        for (int b = 0; b < n_out; b++) begin
            logic last;
            last = (b == n_total - 1) || (b == MAXB - 1);
            exp_q.push_back({2'(src), last, mk_strb(b, n_total), mk_data(src, pkt, b)});
        end
    endtask

    task automatic drive_beat(input int src, input int b, input int n, input int pkt);
        axis_if.S_tvalid[src]            = 1'b1;
        axis_if.S_tdata[src*DW +: DW]    = mk_data(src, pkt, b);
        axis_if.S_tstrb[src*SW +: SW]    = mk_strb(b, n);
        axis_if.S_tlast[src]             = (b == n - 1);
    endtask

    task automatic send_pkt(input int src, input int n, input int pkt);
        bit hs;
        int guard;
        for (int b = 0; b < n; b++) begin
            drive_beat(src, b, n, pkt);
            hs    = 1'b0;
            guard = 0;
            while (!hs && guard < TMO) begin
                @(negedge Clk);
                hs = axis_if.S_tready[src];
                @(posedge Clk);
                #1;
                guard++;
            end
            if (!hs) begin
                n_cmp++;
                n_err++;
                $display("FAIL handshake_timeout: src %0d beat %0d got no ready in %0d cycles", src, b, TMO);
                b = n;
            end
        end
        axis_if.S_tvalid[src] = 1'b0;
        axis_if.S_tlast[src]  = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Reset = 1'b0;
    endtask

    // Monitor: pops one expected beat per accepted output beat.
    initial begin : monitor
        logic [EW-1:0] act;
        logic [EW-1:0] e;
        forever begin
            @(negedge Clk);
            if (!Reset && axis_if.M_tvalid && axis_if.M_tready) begin
                act = {Grant_id, axis_if.M_tlast, axis_if.M_tstrb, axis_if.M_tdata};
                n_beats++;
                beat_cyc.push_back(cyc);
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h with nothing expected", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_err++;
                        $display("FAIL beat: got %0h expected %0h", act, e);
                    end
                end
            end
            if (!Reset && chk_ready && dbg_state == 2'd1) begin
                n_cmp++;
                if (axis_if.S_tready !== (axis_if.M_tready ? 4'b0100 : 4'b0000)) begin
                    n_err++;
                    $display("FAIL s_tready_mirror: got %b with M_tready %b", axis_if.S_tready, axis_if.M_tready);
                end
            end
            if (!Reset && Trunc_err) n_trunc++;
        end
    end

    initial begin : main
        int t0;
        int busy_n;
        int nb0;
        bit done;

        Reset            = 1'b1;
        Src_en           = 4'hF;
        axis_if.S_tvalid = '0;
        axis_if.S_tdata  = '0;
        axis_if.S_tstrb  = '0;
        axis_if.S_tlast  = '0;
        axis_if.M_tready = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_m_tvalid", axis_if.M_tvalid, 0);
        chk("rst_m_tlast", axis_if.M_tlast, 0);
        chk("rst_m_tdata", axis_if.M_tdata, 0);
        chk("rst_s_tready", axis_if.S_tready, 0);
        chk("rst_grant", Grant_id, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_state", dbg_state, 0);
        Reset = 1'b0;

        // Single source, 4-beat packet, back-to-back beats.
        do_reset();
        axis_if.M_tready = 1'b1;
        push_exp(1, 4, 4, 0);
        beat_cyc.delete();
        t0 = cyc;
        fork
            send_pkt(1, 4, 0);
            begin
                @(posedge Clk); #1;
                chk("t1_grant", Grant_id, 1);
            end
            begin
                busy_n = 0;
                repeat (8) begin
                    @(negedge Clk);
                    if (Busy) busy_n++;
                end
                chk("t1_busy_cycles", busy_n, 4);
            end
        join
        chk("t1_beats", beat_cyc.size(), 4);
        for (int k = 0; k < 4 && k < beat_cyc.size(); k++) chk("t1_beat_cycle", beat_cyc[k], t0 + k + 1);
        chk("t1_grant_hold", Grant_id, 1);
        chk("t1_drained", exp_q.size(), 0);

        // All four sources busy: rotation 0,1,2,3,0 with one bubble per packet.
        do_reset();
        push_exp(0, 2, 2, 0);
        push_exp(1, 2, 2, 0);
        push_exp(2, 2, 2, 0);
        push_exp(3, 2, 2, 0);
        push_exp(0, 2, 2, 1);
        beat_cyc.delete();
        t0 = cyc;
        fork
            begin
                send_pkt(0, 2, 0);
                send_pkt(0, 2, 1);
            end
            send_pkt(1, 2, 0);
            send_pkt(2, 2, 0);
            send_pkt(3, 2, 0);
        join
        chk("t2_beats", beat_cyc.size(), 10);
        for (int k = 0; k < 10 && k < beat_cyc.size(); k++)
            chk("t2_beat_cycle", beat_cyc[k], t0 + (k / 2) * 3 + (k % 2) + 1);
        chk("t2_drained", exp_q.size(), 0);

        // Back-pressure from the MAC toggling every cycle.
        do_reset();
        chk_ready = 1'b1;
        done      = 1'b0;
        push_exp(2, 5, 5, 0);
        fork
            begin
                send_pkt(2, 5, 0);
                done = 1'b1;
            end
            begin
                for (int g = 0; g < TMO && !done; g++) begin
                    @(posedge Clk); #1;
                    axis_if.M_tready = ~axis_if.M_tready;
                end
            end
        join
        chk_ready        = 1'b0;
        axis_if.M_tready = 1'b1;
        chk("t3_drained", exp_q.size(), 0);

        // Watchdog: 12 beats offered, 8 forwarded with forced tlast, 4 drained.
        do_reset();
        n_trunc = 0;
        push_exp(0, 8, 12, 0);
        send_pkt(0, 12, 0);
        chk("t4_state_idle", dbg_state, 0);
        chk("t4_busy", Busy, 0);
        chk("t4_trunc_pulses", n_trunc, 1);
        chk("t4_drained", exp_q.size(), 0);

        // Src_en cleared mid-packet: packet completes, then source 1 is skipped.
        do_reset();
        push_exp(1, 4, 4, 0);
        fork
            send_pkt(1, 4, 0);
            begin
                repeat (3) @(posedge Clk);
                #1;
                Src_en[1] = 1'b0;
            end
        join
        chk("t5_first_done", exp_q.size(), 0);
        push_exp(3, 2, 2, 1);
        push_exp(1, 2, 2, 1);
        nb0 = n_beats;
        fork
            send_pkt(3, 2, 1);
            send_pkt(1, 2, 1);
            begin
                repeat (10) @(posedge Clk);
                #1;
                chk("t5_skip_beats", n_beats - nb0, 2);
                chk("t5_skip_idle", dbg_state, 0);
                chk("t5_skip_grant", Grant_id, 3);
                Src_en[1] = 1'b1;
            end
        join
        chk("t5_regrant", Grant_id, 1);
        chk("t5_drained", exp_q.size(), 0);

        // Reset on the third beat of a 6-beat packet from source 2.
        do_reset();
        push_exp(2, 2, 6, 0);
        drive_beat(2, 0, 6, 0);
        @(posedge Clk); #1;
        chk("t6_grant", Grant_id, 2);
        @(posedge Clk); #1;
        drive_beat(2, 1, 6, 0);
        @(posedge Clk); #1;
        drive_beat(2, 2, 6, 0);
        Reset = 1'b1;
        @(posedge Clk); #1;
        chk("t6_m_tvalid", axis_if.M_tvalid, 0);
        chk("t6_m_tlast", axis_if.M_tlast, 0);
        chk("t6_m_tdata", axis_if.M_tdata, 0);
        chk("t6_m_tstrb", axis_if.M_tstrb, 0);
        chk("t6_s_tready", axis_if.S_tready, 0);
        chk("t6_busy", Busy, 0);
        chk("t6_trunc", Trunc_err, 0);
        chk("t6_grant_rst", Grant_id, 0);
        chk("t6_state", dbg_state, 0);
        chk("t6_partial", exp_q.size(), 0);
        axis_if.S_tvalid[2] = 1'b0;
        axis_if.S_tlast[2]  = 1'b0;
        Reset = 1'b0;
        push_exp(2, 1, 1, 1);
        push_exp(3, 1, 1, 0);
        fork
            send_pkt(2, 1, 1);
            send_pkt(3, 1, 0);
            begin
                @(posedge Clk); #1;
                chk("t6_first_grant", Grant_id, 2);
            end
        join
        chk("t6_drained", exp_q.size(), 0);

        repeat (3) @(posedge Clk);
        #1;
        chk("final_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
